// File: rtl/speech256_pkg.sv
// Shared Speech256 definitions: allophone width, pause allophone codes and
// the receiver control FSM state type.
package speech256_pkg;

  localparam int ALLO_W = 6;

  localparam logic [ALLO_W-1:0] ALLO_PA1 = 6'h00;
  localparam logic [ALLO_W-1:0] ALLO_PA2 = 6'h01;
  localparam logic [ALLO_W-1:0] ALLO_PA3 = 6'h02;
  localparam logic [ALLO_W-1:0] ALLO_PA4 = 6'h03;
  localparam logic [ALLO_W-1:0] ALLO_PA5 = 6'h04;

  typedef enum logic [1:0] {
    S_READY = 2'd0,
    S_HOLD  = 2'd1,
    S_FULL  = 2'd2
  } alrx_state_t;

endpackage

// File: rtl/allophone_fifo.sv
// DEPTH x W synchronous FIFO with a registered head word, so the head reads
// 0 out of reset and holds the last popped code while empty.
module allophone_fifo
  import speech256_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = ALLO_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_data,
  output logic [W-1:0]             o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic                     o_full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [W-1:0]  r_head;

  logic          w_push;
  logic          w_pop;
  logic [PW-1:0] w_rd_ptr_inc;
  logic [W-1:0]  w_head_next;

  assign o_empty      = (r_count == '0);
  assign o_full       = (r_count == FULL_CNT);
  assign o_count      = r_count;
  assign o_head       = r_head;
  assign w_push       = i_push & ~o_full;
  assign w_pop        = i_pop & ~o_empty;
  assign w_rd_ptr_inc = r_rd_ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Head bypasses the array when the incoming word becomes the new head.
  always_comb begin
    w_head_next = r_head;
    if (w_push && (r_count == '0 || (w_pop && r_count == ONE_CNT)))
      w_head_next = i_data;
    else if (w_pop && r_count != ONE_CNT)
      w_head_next = r_mem[w_rd_ptr_inc];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= w_rd_ptr_inc;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_head <= w_head_next;
    end
  end

endmodule

// File: rtl/allophone_rx.sv
// Host allophone receiver: strobe edge detect, ldq handshake FSM and FIFO.
// Define ALLOPHONE_RX_OVF_EN to add the sticky ovf flag and its ovf_clr input.
module allophone_rx
  import speech256_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ALLO_W-1:0] data_in,
  input  logic              data_stb,
  output logic              ldq,
  output logic [ALLO_W-1:0] alo_code,
  output logic              alo_valid,
  input  logic              alo_ack,
  output logic              busy
`ifdef ALLOPHONE_RX_OVF_EN
  ,
  output logic              ovf,
  input  logic              ovf_clr
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  alrx_state_t   r_state;
  alrx_state_t   w_state_next;
  logic          r_stb_d;
  logic          w_stb_evt;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_count_after;
  logic          w_empty;
  logic          w_full;

  assign w_stb_evt     = data_stb & ~r_stb_d;
  assign w_pop         = alo_ack & ~w_empty;
  assign w_count_after = w_count - CW'(w_pop);

  assign ldq       = (r_state == S_READY);
  assign alo_valid = ~w_empty;
  assign busy      = ~w_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stb_d <= 1'b0;
      r_state <= S_HOLD;
    end else begin
      r_stb_d <= data_stb;
      r_state <= w_state_next;
    end
  end

  // HOLD waits for the host to release the strobe, so each code is one push.
  always_comb begin
    w_state_next = r_state;
    w_push       = 1'b0;
    case (r_state)
      S_READY: begin
        if (w_stb_evt) begin
          w_push       = 1'b1;
          w_state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!data_stb)
          w_state_next = (w_count_after == FULL_CNT) ? S_FULL : S_READY;
      end
      S_FULL: begin
        if (!w_full) w_state_next = S_READY;
      end
      default: w_state_next = S_HOLD;
    endcase
  end

  allophone_fifo #(
    .DEPTH (DEPTH),
    .W     (ALLO_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (data_in),
    .o_head  (alo_code),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

`ifdef ALLOPHONE_RX_OVF_EN
  logic w_drop;
  logic r_ovf;

  assign w_drop = w_stb_evt & (r_state != S_READY);
  assign ovf    = r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_ovf <= 1'b0;
    else if (w_drop)  r_ovf <= 1'b1;
    else if (ovf_clr) r_ovf <= 1'b0;
  end
`endif

endmodule
